// File: rtl/pn_activity_sequencer.sv
// Burst sequencer for the power-noise aggressor array: staggered thermometer ramp up, hold, ramp down, idle gap.
// Latency: all outputs registered; start accepted on the sampling edge, stop acts on the edge after it is sampled.
// Backpressure: none; start is only honoured in IDLE, stop is latched and drains the current burst gracefully.
module pn_activity_sequencer #(
    parameter int NUM_PN_UNITS = 2,
    parameter int STAGE_CYCLES = 16,
    parameter int ON_CYCLES    = 1000,
    parameter int OFF_CYCLES   = 1000,
    parameter int NUM_BURSTS   = 0,
    parameter int CNT_W        = 32
) (
    input  logic                    dut_clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    output logic [NUM_PN_UNITS-1:0] unit_en,
    output logic                    active,
    output logic                    done,
    output logic [15:0]             burst_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_ON        = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_OFF       = 3'd4
    } state_t;

    // Counters hold "edges since last step"; a step fires when they reach LIMIT-1.
    localparam logic [CNT_W-1:0]        STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]        OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
    localparam logic [15:0]             BURST_LIM  = 16'(NUM_BURSTS);
    localparam logic [NUM_PN_UNITS-1:0] EN_FIRST   = NUM_PN_UNITS'(1);
    localparam logic [NUM_PN_UNITS-1:0] EN_ALL     = '1;

    state_t                    state, state_nxt;
    logic [NUM_PN_UNITS-1:0]   en_nxt;
    logic [NUM_PN_UNITS-1:0]   en_up;
    logic [NUM_PN_UNITS-1:0]   en_dn;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [15:0]               burst_nxt;
    logic [15:0]               burst_inc;
    logic                      done_nxt;
    logic                      stop_pend, stop_pend_nxt;
    logic                      step_down;

    // One-bit thermometer moves; shifting keeps the code thermometer by construction.
    assign en_up     = (unit_en << 1) | EN_FIRST;
    assign en_dn     = unit_en >> 1;
    assign burst_inc = (burst_cnt == 16'hFFFF) ? burst_cnt : burst_cnt + 16'd1;
    assign active    = (state != S_IDLE);

    // State and output registers; async reset clears everything immediately.
    always_ff @(posedge dut_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            unit_en   <= '0;
            cnt       <= '0;
            burst_cnt <= '0;
            done      <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            unit_en   <= en_nxt;
            cnt       <= cnt_nxt;
            burst_cnt <= burst_nxt;
            done      <= done_nxt;
            stop_pend <= stop_pend_nxt;
        end
    end

    // Next-state, thermometer stepping, burst accounting and stop handling.
    always_comb begin
        state_nxt     = state;
        en_nxt        = unit_en;
        cnt_nxt       = cnt;
        burst_nxt     = burst_cnt;
        done_nxt      = 1'b0;
        stop_pend_nxt = stop_pend | stop;
        step_down     = 1'b0;

        case (state)
            S_IDLE: begin
                stop_pend_nxt = 1'b0;
                cnt_nxt       = '0;
                if (start && !stop) begin
                    en_nxt    = EN_FIRST;
                    burst_nxt = '0;
                    // A single unit is already fully on after the first step.
                    state_nxt = (EN_FIRST == EN_ALL) ? S_ON : S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (stop_pend) begin
                    step_down = 1'b1;
                end else if (cnt == STAGE_LAST) begin
                    en_nxt  = en_up;
                    cnt_nxt = '0;
                    if (en_up == EN_ALL) begin
                        state_nxt = S_ON;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_ON: begin
                if (stop_pend || cnt == ON_LAST) begin
                    step_down = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_RAMP_DOWN: begin
                if (cnt == STAGE_LAST) begin
                    step_down = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_OFF: begin
                if (stop_pend) begin
                    // Stopping in the gap ends the run without counting a burst.
                    state_nxt     = S_IDLE;
                    done_nxt      = 1'b1;
                    cnt_nxt       = '0;
                    stop_pend_nxt = 1'b0;
                end else if (cnt == OFF_LAST) begin
                    en_nxt    = EN_FIRST;
                    cnt_nxt   = '0;
                    state_nxt = (EN_FIRST == EN_ALL) ? S_ON : S_RAMP_UP;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                en_nxt        = '0;
                cnt_nxt       = '0;
                stop_pend_nxt = 1'b0;
            end
        endcase

        // Shared ramp-down step: clearing the last bit completes the burst.
        if (step_down) begin
            en_nxt  = en_dn;
            cnt_nxt = '0;
            if (en_dn == '0) begin
                burst_nxt = burst_inc;
                if (stop_pend || (NUM_BURSTS != 0 && burst_inc == BURST_LIM)) begin
                    state_nxt     = S_IDLE;
                    done_nxt      = 1'b1;
                    stop_pend_nxt = 1'b0;
                end else begin
                    state_nxt = S_OFF;
                end
            end else begin
                state_nxt = S_RAMP_DOWN;
            end
        end
    end

endmodule

// File: tb/tb_pn_activity_sequencer.sv
module tb_pn_activity_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // Instance A: N=2, NUM_BURSTS=2
    logic        start_a = 1'b0, stop_a = 1'b0;
    logic [1:0]  en_a;
    logic        active_a, done_a;
    logic [15:0] burst_a;

    // Instance B: N=2, NUM_BURSTS=0 (run until stop)
    logic        start_b = 1'b0, stop_b = 1'b0;
    logic [1:0]  en_b;
    logic        active_b, done_b;
    logic [15:0] burst_b;

    // Instance C: N=1, NUM_BURSTS=1
    logic        start_c = 1'b0, stop_c = 1'b0;
    logic [0:0]  en_c;
    logic        active_c, done_c;
    logic [15:0] burst_c;

    int n_checks = 0;
    int n_pass   = 0;

    pn_activity_sequencer #(.NUM_PN_UNITS(2), .STAGE_CYCLES(4), .ON_CYCLES(8),
                            .OFF_CYCLES(6), .NUM_BURSTS(2), .CNT_W(32)) dut_a (
        .dut_clk(clk), .reset_n(reset_n), .start(start_a), .stop(stop_a),
        .unit_en(en_a), .active(active_a), .done(done_a), .burst_cnt(burst_a));

    pn_activity_sequencer #(.NUM_PN_UNITS(2), .STAGE_CYCLES(4), .ON_CYCLES(8),
                            .OFF_CYCLES(6), .NUM_BURSTS(0), .CNT_W(32)) dut_b (
        .dut_clk(clk), .reset_n(reset_n), .start(start_b), .stop(stop_b),
        .unit_en(en_b), .active(active_b), .done(done_b), .burst_cnt(burst_b));

    pn_activity_sequencer #(.NUM_PN_UNITS(1), .STAGE_CYCLES(4), .ON_CYCLES(8),
                            .OFF_CYCLES(6), .NUM_BURSTS(1), .CNT_W(32)) dut_c (
        .dut_clk(clk), .reset_n(reset_n), .start(start_c), .stop(stop_c),
        .unit_en(en_c), .active(active_c), .done(done_c), .burst_cnt(burst_c));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({en_a, active_a, done_a, burst_a} !== 20'h0) begin
            $display("FAIL reset_a: got en=%b act=%b done=%b burst=%0d, want all zero",
                     en_a, active_a, done_a, burst_a);
        end else n_pass++;
        n_checks++;
        if ({en_b, active_b, done_b, burst_b} !== 20'h0) begin
            $display("FAIL reset_b: got en=%b act=%b done=%b burst=%0d, want all zero",
                     en_b, active_b, done_b, burst_b);
        end else n_pass++;
        n_checks++;
        if ({en_c, active_c, done_c, burst_c} !== 19'h0) begin
            $display("FAIL reset_c: got en=%b act=%b done=%b burst=%0d, want all zero",
                     en_c, active_c, done_c, burst_c);
        end else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Two full bursts on instance A; optional extra start pulse (ignored while busy).
    task automatic run_full(input string name, input int restart_at);
        logic [1:0]  xe;
        logic [15:0] xb;
        for (int e = 0; e <= 42; e++) begin
            start_a = (e == 0) || (e == restart_at);
            tick();
            start_a = 1'b0;
            if (e < 4)       xe = 2'b01;
            else if (e < 12) xe = 2'b11;
            else if (e < 16) xe = 2'b01;
            else if (e < 22) xe = 2'b00;
            else if (e < 26) xe = 2'b01;
            else if (e < 34) xe = 2'b11;
            else if (e < 38) xe = 2'b01;
            else             xe = 2'b00;
            xb = (e < 16) ? 16'd0 : (e < 38) ? 16'd1 : 16'd2;
            n_checks++;
            if ({en_a, active_a, done_a, burst_a} !== {xe, (e < 38), (e == 38), xb}) begin
                $display("FAIL %s edge %0d: got en=%b act=%b done=%b burst=%0d, want en=%b act=%b done=%b burst=%0d",
                         name, e, en_a, active_a, done_a, burst_a, xe, (e < 38), (e == 38), xb);
            end else n_pass++;
        end
    endtask

    task automatic test_full_run();
        run_full("full_run", -1);
    endtask

    task automatic test_start_in_on();
        run_full("start_in_on", 6);
    endtask

    task automatic test_stop_in_on();
        logic [1:0]  xe;
        logic [15:0] xb;
        for (int e = 0; e <= 14; e++) begin
            start_b = (e == 0);
            stop_b  = (e == 6);
            tick();
            start_b = 1'b0;
            stop_b  = 1'b0;
            if (e < 4)       xe = 2'b01;
            else if (e < 7)  xe = 2'b11;
            else if (e < 11) xe = 2'b01;
            else             xe = 2'b00;
            xb = (e < 11) ? 16'd0 : 16'd1;
            n_checks++;
            if ({en_b, active_b, done_b, burst_b} !== {xe, (e < 11), (e == 11), xb}) begin
                $display("FAIL stop_in_on edge %0d: got en=%b act=%b done=%b burst=%0d, want en=%b act=%b done=%b burst=%0d",
                         e, en_b, active_b, done_b, burst_b, xe, (e < 11), (e == 11), xb);
            end else n_pass++;
        end
    endtask

    task automatic test_stop_in_off();
        logic [1:0]  xe;
        logic [15:0] xb;
        for (int e = 0; e <= 22; e++) begin
            start_b = (e == 0);
            stop_b  = (e == 18);
            tick();
            start_b = 1'b0;
            stop_b  = 1'b0;
            if (e < 4)       xe = 2'b01;
            else if (e < 12) xe = 2'b11;
            else if (e < 16) xe = 2'b01;
            else             xe = 2'b00;
            xb = (e < 16) ? 16'd0 : 16'd1;
            n_checks++;
            if ({en_b, active_b, done_b, burst_b} !== {xe, (e < 19), (e == 19), xb}) begin
                $display("FAIL stop_in_off edge %0d: got en=%b act=%b done=%b burst=%0d, want en=%b act=%b done=%b burst=%0d",
                         e, en_b, active_b, done_b, burst_b, xe, (e < 19), (e == 19), xb);
            end else n_pass++;
        end
    endtask

    // Instance B sits in IDLE with burst_cnt=1 from the previous run.
    task automatic test_start_stop_idle();
        start_b = 1'b1;
        stop_b  = 1'b1;
        tick();
        start_b = 1'b0;
        stop_b  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({en_b, active_b, done_b, burst_b} !== {2'b00, 1'b0, 1'b0, 16'd1}) begin
                $display("FAIL start_stop_idle cycle %0d: got en=%b act=%b done=%b burst=%0d, want en=00 act=0 done=0 burst=1",
                         i, en_b, active_b, done_b, burst_b);
            end else n_pass++;
            tick();
        end
    endtask

    task automatic test_single_unit();
        logic [15:0] xb;
        for (int e = 0; e <= 10; e++) begin
            start_c = (e == 0);
            tick();
            start_c = 1'b0;
            xb = (e < 8) ? 16'd0 : 16'd1;
            n_checks++;
            if ({en_c, active_c, done_c, burst_c} !== {(e < 8), (e < 8), (e == 8), xb}) begin
                $display("FAIL single_unit edge %0d: got en=%b act=%b done=%b burst=%0d, want en=%b act=%b done=%b burst=%0d",
                         e, en_c, active_c, done_c, burst_c, (e < 8), (e < 8), (e == 8), xb);
            end else n_pass++;
        end
    endtask

    // Reset asserted during the second burst's ON phase must clear outputs without a clock edge.
    task automatic test_reset_mid_on();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int e = 1; e <= 28; e++) tick();
        n_checks++;
        if ({en_a, active_a, burst_a} !== {2'b11, 1'b1, 16'd1}) begin
            $display("FAIL pre_reset_on: got en=%b act=%b burst=%0d, want en=11 act=1 burst=1",
                     en_a, active_a, burst_a);
        end else n_pass++;
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({en_a, active_a, done_a, burst_a} !== 20'h0) begin
            $display("FAIL reset_mid_on: got en=%b act=%b done=%b burst=%0d, want all zero",
                     en_a, active_a, done_a, burst_a);
        end else n_pass++;
        tick();
        n_checks++;
        if ({en_a, active_a, done_a, burst_a} !== 20'h0) begin
            $display("FAIL reset_held: got en=%b act=%b done=%b burst=%0d, want all zero",
                     en_a, active_a, done_a, burst_a);
        end else n_pass++;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_start_in_on();
        test_stop_in_on();
        test_stop_in_off();
        test_start_stop_idle();
        test_single_unit();
        test_reset_mid_on();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
